sbc: RTL and testbench
======================

SBC -- requirements
Module: sbc

Interface
REQ-001 SHALL have parameter WIDTH, default 4, binary word width; window length LEN = 2^WIDTH-1 (15 at default).
REQ-002 SHALL have i_clk_sbc  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have i_rst_sbc  input  1  reset, synchronous, active-high.
REQ-004 SHALL have i_sn_bit  input  1  unipolar stochastic bit stream, one bit per cycle.
REQ-005 SHALL have i_start_sbc  input  1  one-cycle pulse, begins conversion.
REQ-006 SHALL have i_stop_sbc  input  1  one-cycle pulse, ends conversion.
REQ-007 SHALL have o_x_bn  output  WIDTH  decoded binary value (ones count of last complete window).
REQ-008 SHALL have o_valid_sbc  output  1  one-cycle pulse; o_x_bn updated this cycle.
REQ-009 SHALL have o_busy_sbc  output  1  high while in COUNT.

Function
REQ-010 SHALL implement FSM with states IDLE and COUNT.
- IDLE -> COUNT on i_start_sbc.
- COUNT -> IDLE on i_stop_sbc.
REQ-011 SHALL sample i_sn_bit on every edge where state is COUNT. The first sample is taken on the edge after the edge that accepted start. This aligns with a generator that emits its first bit the cycle after start.
REQ-012 SHALL keep a sample counter (0..LEN-1) and a ones counter (0..LEN). Both are cleared on entry to COUNT.
REQ-013 On the edge taking the LEN-th sample, SHALL:
- register o_x_bn <= ones + i_sn_bit;
- assert o_valid_sbc for exactly the following cycle;
- clear both counters and remain in COUNT (continuous back-to-back windows, no gap cycle).
REQ-014 SHALL hold o_x_bn between updates; o_x_bn SHALL change only together with o_valid_sbc.
REQ-015 Ones count SHALL never exceed LEN, so no saturation is needed; arithmetic is unsigned WIDTH bits.
REQ-016 A stop in COUNT SHALL discard the partial window: no valid pulse, o_x_bn unchanged, counters cleared, state IDLE.
REQ-017 Stop on the same edge as the LEN-th sample SHALL take priority: no valid pulse, o_x_bn unchanged.
REQ-018 Start while in COUNT SHALL restart the window: counters cleared, current-edge bit not counted, no valid pulse.
REQ-019 Start and stop together SHALL act as stop: go to or stay in IDLE.
REQ-020 i_sn_bit SHALL be ignored in IDLE; stop in IDLE SHALL be a no-op.
REQ-021 o_busy_sbc SHALL equal (state == COUNT), registered.

Reset
REQ-022 i_rst_sbc SHALL override all other inputs on the same edge.
REQ-023 Reset values: state IDLE, counters 0, o_x_bn 0, o_valid_sbc 0, o_busy_sbc 0.
REQ-024 Reset mid-window SHALL discard the partial window with no valid pulse.

Structure
REQ-025 Shared package sc_pkg SHALL hold WIDTH default, the LEN function/constant, and the state enum (IDLE, COUNT) for reuse by the generator and converter.
REQ-026 Sub-module sbc_win_cnt SHALL contain the sample/ones counter pair, with clear, enable and bit inputs and a last-sample flag output; FSM and output registers stay in sbc.
REQ-027 The design SHALL contain no latches, no combinational input-to-output paths, and no multiple drivers.

Verification
REQ-028 Bench SHALL cover these directed scenarios:
- Reset 2 cycles, start, 15 cycles of i_sn_bit=1 -> o_valid_sbc pulses once on cycle 16 after start, o_x_bn=15.
- Chain with the stochastic number generator (x=6), start both together, run 100 cycles, then stop -> 6 valid pulses spaced 15 cycles apart, each with o_x_bn=6, o_busy_sbc low after stop.
- Start, feed pattern 1010..., stop after 7 samples -> no valid pulse, o_x_bn holds previous value, state IDLE.
- Stop asserted on the 15th-sample edge -> no valid pulse; separately, start on sample 9 -> next valid 15 samples later, counting only new bits.
- Assert reset on sample 10 with all-ones input -> all outputs 0 next cycle, no valid pulse; start and stop together in IDLE -> o_busy_sbc stays 0.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions.
// Used by both the number generator and the converter.
package sc_pkg;

    localparam int SC_WIDTH = 4;

    function automatic int sc_len(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int SC_LEN = sc_len(SC_WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } sc_state_e;

endpackage

// File: rtl/sbc_if.sv
// Stream bundle between a stochastic bit source and the converter.
// The master drives the bit stream and control pulses; the slave returns results.
interface sbc_if
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH
);

    logic             sn_bit;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] x_bn;
    logic             valid;
    logic             busy;

    modport master (
        output sn_bit,
        output start,
        output stop,
        input  x_bn,
        input  valid,
        input  busy
    );

    modport slave (
        input  sn_bit,
        input  start,
        input  stop,
        output x_bn,
        output valid,
        output busy
    );

endinterface

// File: rtl/sbc_win_cnt.sv
// Window counters: sample position and ones seen in the current window.
// Both wrap to zero after the last sample of a window.
module sbc_win_cnt
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic             last_o,
    output logic [WIDTH-1:0] ones_o
);

    localparam int LEN = sc_len(WIDTH);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] ones_q;
    logic [WIDTH-1:0] ones_d;

    assign last_o = (cnt_q == WIDTH'(LEN - 1));
    assign ones_o = ones_q;

    always_comb begin
        cnt_d  = cnt_q;
        ones_d = ones_q;
        if (clr_i || (en_i && last_o)) begin
            cnt_d  = '0;
            ones_d = '0;
        end else if (en_i) begin
            cnt_d  = cnt_q + WIDTH'(1);
            ones_d = ones_q + WIDTH'(bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            ones_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/sbc.sv
// Stochastic-to-binary converter: counts ones over back-to-back
// windows of 2^WIDTH-1 samples and publishes each complete count.
module sbc
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH
) (
    input  logic             i_clk_sbc,
    input  logic             i_rst_sbc,
    input  logic             i_sn_bit,
    input  logic             i_start_sbc,
    input  logic             i_stop_sbc,
    output logic [WIDTH-1:0] o_x_bn,
    output logic             o_valid_sbc,
    output logic             o_busy_sbc
);

    sc_state_e        state_q;
    sc_state_e        state_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] x_d;
    logic             valid_q;
    logic             valid_d;
    logic             busy_q;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic [WIDTH-1:0] cnt_ones;

    sbc_win_cnt #(
        .WIDTH (WIDTH)
    ) u_win_cnt (
        .clk_i  (i_clk_sbc),
        .rst_i  (i_rst_sbc),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .bit_i  (i_sn_bit),
        .last_o (cnt_last),
        .ones_o (cnt_ones)
    );

    // Stop beats start and beats a completing window.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        valid_d = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start_sbc && !i_stop_sbc) begin
                    state_d = COUNT;
                    cnt_clr = 1'b1;
                end
            end
            COUNT: begin
                unique case (1'b1)
                    i_stop_sbc: begin
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                    end
                    i_start_sbc: begin
                        cnt_clr = 1'b1;
                    end
                    default: begin
                        cnt_en = 1'b1;
                        if (cnt_last) begin
                            x_d     = cnt_ones + WIDTH'(i_sn_bit);
                            valid_d = 1'b1;
                        end
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_sbc) begin
        if (i_rst_sbc) begin
            state_q <= IDLE;
            x_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= (state_d == COUNT);
        end
    end

    assign o_x_bn      = x_q;
    assign o_valid_sbc = valid_q;
    assign o_busy_sbc  = busy_q;

endmodule

// File: tb/tb_sbc.sv
// Bench for sbc: directed table, generator chain, corner sequences
// and random traffic against a queue-based window model.
module tb_sbc;
    import sc_pkg::*;

    localparam int W = 4;
    localparam int L = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sbc_if #(.WIDTH(W)) sif ();

    sbc #(.WIDTH(W)) dut (
        .i_clk_sbc   (clk),
        .i_rst_sbc   (rst),
        .i_sn_bit    (sif.sn_bit),
        .i_start_sbc (sif.start),
        .i_stop_sbc  (sif.stop),
        .o_x_bn      (sif.x_bn),
        .o_valid_sbc (sif.valid),
        .o_busy_sbc  (sif.busy)
    );

    typedef struct {
        bit r;
        bit st;
        bit sp;
        bit sn;
        bit ev;
        int ex;
        bit eb;
    } vec_t;

    int checks = 0;
    int errors = 0;

    bit run = 1'b0;
    bit q[$];
    int mx = 0;
    bit mv = 1'b0;

    int cyc = 0;
    int npulse = 0;
    int lastp = 0;
    int gap = 0;
    bit [3:0] lfsr;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit st,
                        input bit sp, input bit sn);
        @(negedge clk);
        rst        = r;
        sif.start  = st;
        sif.stop   = sp;
        sif.sn_bit = sn;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            run = 1'b0;
            q.delete();
            mx = 0;
            mv = 1'b0;
        end else begin
            mv = 1'b0;
            if (sp) begin
                run = 1'b0;
                q.delete();
            end else if (st) begin
                run = 1'b1;
                q.delete();
            end else if (run) begin
                q.push_back(sn);
                if (q.size() == L) begin
                    mx = 0;
                    foreach (q[k]) mx += int'(q[k]);
                    mv = 1'b1;
                    q.delete();
                end
            end
        end
        chk("model_x", int'(sif.x_bn), mx);
        chk("model_valid", int'(sif.valid), int'(mv));
        chk("model_busy", int'(sif.busy), int'(run));
        if (sif.valid === 1'b1) begin
            npulse++;
            gap   = cyc - lastp;
            lastp = cyc;
        end
    endtask

    vec_t tbl[19];

    initial begin
        sif.sn_bit = 1'b0;
        sif.start  = 1'b0;
        sif.stop   = 1'b0;

        // Reset twice, start, fifteen ones, then one more sample.
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 1, 0, 0, 1};
        for (int i = 0; i < 15; i++)
            tbl[3 + i] = '{0, 0, 0, 1, (i == 14), (i == 14) ? 15 : 0, 1};
        tbl[18] = '{0, 0, 0, 0, 0, 15, 1};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].r, tbl[i].st, tbl[i].sp, tbl[i].sn);
            chk("tbl_valid", int'(sif.valid), int'(tbl[i].ev));
            chk("tbl_x", int'(sif.x_bn), tbl[i].ex);
            chk("tbl_busy", int'(sif.busy), int'(tbl[i].eb));
        end
        step(0, 0, 1, 0);

        // Generator chain at x=6: LFSR states 1..15 compared to x.
        npulse = 0;
        step(0, 1, 0, 0);
        lfsr = 4'd1;
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0, (lfsr <= 4'd6));
            lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            if (sif.valid === 1'b1) begin
                chk("gen_x", int'(sif.x_bn), 6);
                if (npulse > 1) chk("gen_gap", gap, 15);
            end
        end
        step(0, 0, 1, 0);
        chk("gen_pulses", npulse, 6);
        chk("gen_busy_after_stop", int'(sif.busy), 0);

        // Partial window then stop: nothing published.
        npulse = 0;
        step(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, (i % 2 == 0));
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("partial_pulses", npulse, 0);
        chk("partial_x", int'(sif.x_bn), 6);
        chk("partial_busy", int'(sif.busy), 0);

        // Stop coincident with the fifteenth sample wins.
        step(0, 1, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        chk("stop15_pulses", npulse, 0);
        chk("stop15_x", int'(sif.x_bn), 6);

        // Restart on sample 9: only the fresh 15 bits count.
        step(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, (i % 2 == 1));
            chk("restart_valid", int'(sif.valid), int'(i == 14));
        end
        chk("restart_x", int'(sif.x_bn), 7);
        step(0, 0, 1, 0);

        // Reset mid-window with all-ones input.
        npulse = 0;
        step(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("rst_x", int'(sif.x_bn), 0);
        chk("rst_valid", int'(sif.valid), 0);
        chk("rst_busy", int'(sif.busy), 0);
        step(0, 1, 1, 1);
        chk("startstop_busy", int'(sif.busy), 0);
        step(0, 0, 0, 1);
        chk("startstop_busy2", int'(sif.busy), 0);
        chk("rst_pulses", npulse, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 200) == 0,
                 ($urandom % 30) == 0,
                 ($urandom % 50) == 0,
                 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
